// File: rtl/fifo_param_if.sv
// Handshake/data bundle between a FIFO user (master) and fifo_param (slave).
// Widths follow the FIFO's DATA_WIDTH / ADDR_WIDTH.
interface fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] Data_In;
    logic                  Write;
    logic                  Read;
    logic                  Clear_Err;
    logic [DATA_WIDTH-1:0] Data_Out;
    logic                  Data_Valid;
    logic [3:0]            Fifo_Status;
    logic [ADDR_WIDTH:0]   Count;
    logic                  Overflow;
    logic                  Underflow;

    modport master (
        output Data_In, Write, Read, Clear_Err,
        input  Data_Out, Data_Valid, Fifo_Status, Count, Overflow, Underflow
    );

    modport slave (
        input  Data_In, Write, Read, Clear_Err,
        output Data_Out, Data_Valid, Fifo_Status, Count, Overflow, Underflow
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised falling-edge synchronous FIFO with full 2^ADDR_WIDTH usage,
// threshold status, sticky error flags and optional first-word fall-through.
module fifo_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_LEVEL  = (2**ADDR_WIDTH) - 2,
    parameter int AEMPTY_LEVEL = 2,
    parameter int FWFT         = 0
) (
    input  logic          Clk,
    input  logic          Reset,
    fifo_param_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [3:0] STATUS_RESET = 4'b1001;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0] count, count_next;
    logic [3:0]          status_reg, status_next;
    logic                ovf_reg, ovf_next;
    logic                unf_reg, unf_next;
    logic                rd_acc, wr_acc;

    // Extra pointer MSB separates full from empty; difference is the occupancy.
    always_comb begin
        count  = wr_ptr_reg - rd_ptr_reg;
        rd_acc = bus.Read && (count != '0);
        wr_acc = bus.Write && ((count != DEPTH_CNT) || rd_acc);

        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_acc) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (rd_acc) rd_ptr_next = rd_ptr_reg + 1'b1;
        count_next = wr_ptr_next - rd_ptr_next;

        status_next    = '0;
        status_next[0] = (count_next == '0);
        status_next[1] = (count_next == DEPTH_CNT);
        status_next[2] = (int'(count_next) >= AFULL_LEVEL);
        status_next[3] = (int'(count_next) <= AEMPTY_LEVEL);

        // Clear first, then a rejection in the same cycle re-sets the flag.
        ovf_next = (ovf_reg && !bus.Clear_Err) || (bus.Write && !wr_acc);
        unf_next = (unf_reg && !bus.Clear_Err) || (bus.Read && !rd_acc);
    end

    always_ff @(negedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            status_reg <= STATUS_RESET;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            status_reg <= status_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
        end
    end

    // Storage is never reset; stale words are unreachable once pointers clear.
    always_ff @(negedge Clk) begin
        if (wr_acc) mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= bus.Data_In;
    end

    assign bus.Count       = count;
    assign bus.Fifo_Status = status_reg;
    assign bus.Overflow    = ovf_reg;
    assign bus.Underflow   = unf_reg;

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.Data_Valid = (count != '0);
            assign bus.Data_Out   = (count != '0) ? mem[rd_ptr_reg[ADDR_WIDTH-1:0]] : '0;
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] data_out_reg;
            logic                  data_valid_reg;

            always_ff @(negedge Clk or negedge Reset) begin
                if (!Reset) begin
                    data_out_reg   <= '0;
                    data_valid_reg <= 1'b0;
                end else begin
                    data_valid_reg <= rd_acc;
                    if (rd_acc) data_out_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
                end
            end

            assign bus.Data_Out   = data_out_reg;
            assign bus.Data_Valid = data_valid_reg;
        end
    endgenerate
endmodule
